hazard_detection_unit: RTL and testbench
========================================

Name: hazard_detection_unit

Overview:
- Stall-side counterpart of the EX-stage forwarding logic in the 5-stage RV32I pipeline; sits in ID and governs the pipeline-register write enables.
- Detects hazards that forwarding cannot cover:
  - load-use on rs1/rs2;
  - ecall reading x17 before the value is forwardable;
  - variable-latency data-memory accesses.
- Drives PC, IF/ID, ID/EX and EX/MEM write enables, the ID/EX and MEM/WB bubble controls, and a pair of performance counters.

Parameters:
- ECALL_REG, 17, architectural register read by ecall in ID.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high reset.
- IF_ID_inst  input  32  instruction currently in ID.
- ID_EX_rd  input  5  destination of the instruction in EX.
- ID_EX_reg_write  input  1  EX instruction writes rd.
- ID_EX_mem_read  input  1  EX instruction is a load.
- EX_MEM_rd  input  5  destination of the instruction in MEM.
- EX_MEM_mem_read  input  1  MEM instruction is a load.
- dmem_req  input  1  MEM stage is issuing a data-memory access this cycle.
- dmem_ready  input  1  data memory completes the access this cycle.
- pc_write  output  1  PC register enable.
- IF_ID_write  output  1  IF/ID enable.
- ID_EX_write  output  1  ID/EX enable.
- ID_EX_bubble  output  1  load ID/EX with a NOP (all control 0).
- EX_MEM_write  output  1  EX/MEM enable.
- MEM_WB_bubble  output  1  load MEM/WB with a NOP.
- stall_cycles  output  CNT_W  count of cycles with pc_write=0.
- load_use_stalls  output  CNT_W  count of load-use and ecall bubbles inserted.

Behaviour:
- Decode from IF_ID_inst:
  - rs1 = [19:15], rs2 = [24:20].
  - use_rs1 is true except for opcodes LUI 0110111, AUIPC 0010111 and JAL 1101111.
  - use_rs2 is true only for R 0110011, S 0100011 and B 1100011.
  - is_ecall when inst == 32'h00000073.
- load_use = ID_EX_mem_read && ID_EX_rd != 0 && ((use_rs1 && rs1 == ID_EX_rd) || (use_rs2 && rs2 == ID_EX_rd)).
- ecall_haz = is_ecall && ((ID_EX_reg_write && ID_EX_rd == ECALL_REG) || (EX_MEM_mem_read && EX_MEM_rd == ECALL_REG)).
- id_stall = load_use || ecall_haz.
- FSM, 2 states, registered:
  - RUN -> MEM_WAIT when dmem_req && !dmem_ready.
  - MEM_WAIT -> RUN when dmem_ready; otherwise stay in MEM_WAIT.
  - reset -> RUN.
- mem_stall = dmem_req && !dmem_ready, evaluated in either state. This gives zero added latency when memory is ready in the same cycle.
- Outputs are combinational, in priority order:
  1. mem_stall: pc_write, IF_ID_write, ID_EX_write and EX_MEM_write = 0; ID_EX_bubble = 0; MEM_WB_bubble = 1. The whole front end freezes and id_stall is ignored.
  2. else id_stall: pc_write = 0, IF_ID_write = 0, ID_EX_bubble = 1; ID_EX_write, EX_MEM_write = 1; MEM_WB_bubble = 0.
  3. else: all enables 1, both bubbles 0.
- Load-use stalls exactly 1 cycle. ecall stalls 1 cycle per hazard source, 2 cycles worst case (a load to x17 in EX).
- The cycle dmem_ready rises ends the freeze. If the ID hazard still holds, it stalls the following cycle.
- Counters:
  - Both use synchronous reset to 0.
  - stall_cycles increments every non-reset cycle with pc_write == 0.
  - load_use_stalls increments each cycle id_stall && !mem_stall.
  - Both wrap modulo 2^CNT_W.
- While reset is high:
  - all enables = 1, both bubbles = 0;
  - state = RUN;
  - counters cleared the next edge.
- Reset mid-MEM_WAIT returns to RUN with no residual freeze.
- x0 is never a hazard; rd == 0 is ignored.

Test Plan:
- lw x5,0(x0) in EX; add x6,x5,x1 in ID -> one cycle with pc_write=0, IF_ID_write=0, ID_EX_bubble=1; next cycle all enables 1; load_use_stalls = 1.
- lw x0 in EX; add x6,x0,x0 in ID -> no stall. LUI x5 in ID behind lw x5 -> no stall (rs1 unused).
- ecall in ID with addi x17 in EX -> 1 stall. With lw x17 in EX -> 2 consecutive stalls, then proceed; stall_cycles = 2.
- dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> 3 cycles with all enables 0 and MEM_WB_bubble=1; state returns to RUN; stall_cycles = 3.
- Load-use in ID coincident with mem_stall -> freeze takes priority, ID_EX_bubble=0 during the freeze. After ready, 1 load-use bubble; load_use_stalls = 1.
- reset asserted during MEM_WAIT -> next cycle state RUN, counters 0, all enables 1.

Source files
------------

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard detection for the 5-stage RV32I pipeline: load-use, ecall/x17 and
// variable-latency data-memory stalls, plus stall performance counters.
module hazard_detection_unit #(
  parameter int unsigned ECALL_REG = 17,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IF_ID_inst,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_reg_write,
  input  logic             ID_EX_mem_read,
  input  logic [4:0]       EX_MEM_rd,
  input  logic             EX_MEM_mem_read,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             ID_EX_bubble,
  output logic             EX_MEM_write,
  output logic             MEM_WB_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] load_use_stalls
);

  localparam logic [4:0]  ECALL_RD  = 5'(ECALL_REG);
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_S      = 7'b0100011;
  localparam logic [6:0]  OP_B      = 7'b1100011;
  localparam logic [31:0] INST_ECALL = 32'h0000_0073;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [6:0] w_opcode;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_use_rs1;
  logic       w_use_rs2;
  logic       w_is_ecall;
  logic       w_load_use;
  logic       w_ecall_haz;
  logic       w_id_stall;
  logic       w_mem_stall;

  assign w_opcode   = IF_ID_inst[6:0];
  assign w_rs1      = IF_ID_inst[19:15];
  assign w_rs2      = IF_ID_inst[24:20];
  assign w_use_rs1  = !((w_opcode == OP_LUI) || (w_opcode == OP_AUIPC) || (w_opcode == OP_JAL));
  assign w_use_rs2  = (w_opcode == OP_R) || (w_opcode == OP_S) || (w_opcode == OP_B);
  assign w_is_ecall = (IF_ID_inst == INST_ECALL);

  // x0 never creates a dependency, so rd == 0 suppresses load-use.
  assign w_load_use  = ID_EX_mem_read && (ID_EX_rd != 5'd0) &&
                       ((w_use_rs1 && (w_rs1 == ID_EX_rd)) || (w_use_rs2 && (w_rs2 == ID_EX_rd)));
  assign w_ecall_haz = w_is_ecall &&
                       ((ID_EX_reg_write && (ID_EX_rd == ECALL_RD)) ||
                        (EX_MEM_mem_read && (EX_MEM_rd == ECALL_RD)));
  assign w_id_stall  = w_load_use || w_ecall_haz;
  assign w_mem_stall = dmem_req && !dmem_ready;

  // Memory-wait state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic for the memory-wait FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (w_mem_stall) w_state_nxt = MEM_WAIT;
        else             w_state_nxt = RUN;
      end
      MEM_WAIT: begin
        if (dmem_ready) w_state_nxt = RUN;
        else            w_state_nxt = MEM_WAIT;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Pipeline enables and bubbles; a memory freeze overrides any ID hazard.
  always_comb begin
    pc_write      = 1'b1;
    IF_ID_write   = 1'b1;
    ID_EX_write   = 1'b1;
    ID_EX_bubble  = 1'b0;
    EX_MEM_write  = 1'b1;
    MEM_WB_bubble = 1'b0;
    if (reset) begin
      pc_write      = 1'b1;
      MEM_WB_bubble = 1'b0;
    end else if (w_mem_stall) begin
      pc_write      = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EX_write   = 1'b0;
      EX_MEM_write  = 1'b0;
      MEM_WB_bubble = 1'b1;
    end else if (w_id_stall) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end else begin
      pc_write = 1'b1;
    end
  end

  // Performance counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles    <= {CNT_W{1'b0}};
      load_use_stalls <= {CNT_W{1'b0}};
    end else begin
      if (!pc_write) stall_cycles <= stall_cycles + CNT_ONE;
      if (w_id_stall && !w_mem_stall) load_use_stalls <= load_use_stalls + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed self-checking bench for hazard_detection_unit.
module tb_hazard_detection_unit;

  logic        clk;
  logic        reset;
  logic [31:0] IF_ID_inst;
  logic [4:0]  ID_EX_rd;
  logic        ID_EX_reg_write;
  logic        ID_EX_mem_read;
  logic [4:0]  EX_MEM_rd;
  logic        EX_MEM_mem_read;
  logic        dmem_req;
  logic        dmem_ready;
  logic        pc_write;
  logic        IF_ID_write;
  logic        ID_EX_write;
  logic        ID_EX_bubble;
  logic        EX_MEM_write;
  logic        MEM_WB_bubble;
  logic [31:0] stall_cycles;
  logic [31:0] load_use_stalls;

  int n_cmp;
  int n_bad;

  // {pc_write, IF_ID_write, ID_EX_write, ID_EX_bubble, EX_MEM_write, MEM_WB_bubble}
  localparam logic [5:0] P_RUN    = 6'b111010;
  localparam logic [5:0] P_STALL  = 6'b001110;
  localparam logic [5:0] P_FREEZE = 6'b000001;

  localparam logic [31:0] I_ADD_X6_X5_X1 = 32'h0012_8333;
  localparam logic [31:0] I_ADD_X6_X0_X0 = 32'h0000_0333;
  localparam logic [31:0] I_LUI_X5       = 32'h0002_82B7;
  localparam logic [31:0] I_SW_X5        = 32'h0050_A023;
  localparam logic [31:0] I_ADDI_X6_X1_5 = 32'h0050_8313;
  localparam logic [31:0] I_ECALL        = 32'h0000_0073;
  localparam logic [31:0] I_NOP          = 32'h0000_0013;

  logic [5:0] w_pat;
  assign w_pat = {pc_write, IF_ID_write, ID_EX_write, ID_EX_bubble, EX_MEM_write, MEM_WB_bubble};

  hazard_detection_unit #(.ECALL_REG(17), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .IF_ID_inst(IF_ID_inst),
    .ID_EX_rd(ID_EX_rd), .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_mem_read(ID_EX_mem_read),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_mem_read(EX_MEM_mem_read),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
    .ID_EX_bubble(ID_EX_bubble), .EX_MEM_write(EX_MEM_write), .MEM_WB_bubble(MEM_WB_bubble),
    .stall_cycles(stall_cycles), .load_use_stalls(load_use_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    IF_ID_inst = I_NOP; ID_EX_rd = 5'd0; ID_EX_reg_write = 1'b0; ID_EX_mem_read = 1'b0;
    EX_MEM_rd = 5'd0; EX_MEM_mem_read = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_ex(input logic [4:0] rd, input logic rw, input logic mr);
    ID_EX_rd = rd; ID_EX_reg_write = rw; ID_EX_mem_read = mr;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    IF_ID_inst = I_ADD_X6_X5_X1; set_ex(5'd5, 1'b1, 1'b1);
    dmem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    n_cmp++; if (w_pat !== P_RUN) begin n_bad++; $display("FAIL reset_outputs got %b want %b", w_pat, P_RUN); end
    @(negedge clk); @(negedge clk);
    n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cycles); end
    n_cmp++; if (load_use_stalls !== 32'd0) begin n_bad++; $display("FAIL reset_lu_cnt got %0d want 0", load_use_stalls); end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    IF_ID_inst = I_ADD_X6_X5_X1; set_ex(5'd5, 1'b1, 1'b1); #1;
    n_cmp++; if (w_pat !== P_STALL) begin n_bad++; $display("FAIL lu_stall got %b want %b", w_pat, P_STALL); end
    @(negedge clk);
    set_ex(5'd0, 1'b0, 1'b0); #1;
    n_cmp++; if (w_pat !== P_RUN) begin n_bad++; $display("FAIL lu_resume got %b want %b", w_pat, P_RUN); end
    n_cmp++; if (load_use_stalls !== 32'd1) begin n_bad++; $display("FAIL lu_count got %0d want 1", load_use_stalls); end
    n_cmp++; if (stall_cycles !== 32'd1) begin n_bad++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cycles); end
    @(negedge clk);
    IF_ID_inst = I_SW_X5; set_ex(5'd5, 1'b1, 1'b1); #1;
    n_cmp++; if (w_pat !== P_STALL) begin n_bad++; $display("FAIL lu_store_rs2 got %b want %b", w_pat, P_STALL); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_no_hazard();
    do_reset();
    IF_ID_inst = I_ADD_X6_X0_X0; set_ex(5'd0, 1'b1, 1'b1); #1;
    n_cmp++; if (w_pat !== P_RUN) begin n_bad++; $display("FAIL x0_no_stall got %b want %b", w_pat, P_RUN); end
    @(negedge clk);
    IF_ID_inst = I_LUI_X5; set_ex(5'd5, 1'b1, 1'b1); #1;
    n_cmp++; if (w_pat !== P_RUN) begin n_bad++; $display("FAIL lui_no_stall got %b want %b", w_pat, P_RUN); end
    @(negedge clk);
    IF_ID_inst = I_ADDI_X6_X1_5; #1;
    n_cmp++; if (w_pat !== P_RUN) begin n_bad++; $display("FAIL itype_rs2_unused got %b want %b", w_pat, P_RUN); end
    @(negedge clk);
    IF_ID_inst = I_ADD_X6_X5_X1; set_ex(5'd5, 1'b1, 1'b0); #1;
    n_cmp++; if (w_pat !== P_RUN) begin n_bad++; $display("FAIL nonload_no_stall got %b want %b", w_pat, P_RUN); end
    n_cmp++; if (load_use_stalls !== 32'd0) begin n_bad++; $display("FAIL nohaz_lu_count got %0d want 0", load_use_stalls); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_ecall();
    do_reset();
    IF_ID_inst = I_ECALL; set_ex(5'd17, 1'b1, 1'b0); #1;
    n_cmp++; if (w_pat !== P_STALL) begin n_bad++; $display("FAIL ecall_addi_stall got %b want %b", w_pat, P_STALL); end
    @(negedge clk);
    set_ex(5'd0, 1'b0, 1'b0); EX_MEM_rd = 5'd17; EX_MEM_mem_read = 1'b0; #1;
    n_cmp++; if (w_pat !== P_RUN) begin n_bad++; $display("FAIL ecall_addi_go got %b want %b", w_pat, P_RUN); end
    do_reset();
    IF_ID_inst = I_ECALL; set_ex(5'd17, 1'b1, 1'b1); #1;
    n_cmp++; if (w_pat !== P_STALL) begin n_bad++; $display("FAIL ecall_lw_stall1 got %b want %b", w_pat, P_STALL); end
    @(negedge clk);
    set_ex(5'd0, 1'b0, 1'b0); EX_MEM_rd = 5'd17; EX_MEM_mem_read = 1'b1; #1;
    n_cmp++; if (w_pat !== P_STALL) begin n_bad++; $display("FAIL ecall_lw_stall2 got %b want %b", w_pat, P_STALL); end
    @(negedge clk);
    EX_MEM_rd = 5'd0; EX_MEM_mem_read = 1'b0; #1;
    n_cmp++; if (w_pat !== P_RUN) begin n_bad++; $display("FAIL ecall_lw_go got %b want %b", w_pat, P_RUN); end
    n_cmp++; if (stall_cycles !== 32'd2) begin n_bad++; $display("FAIL ecall_stall_cnt got %0d want 2", stall_cycles); end
    n_cmp++; if (load_use_stalls !== 32'd2) begin n_bad++; $display("FAIL ecall_lu_cnt got %0d want 2", load_use_stalls); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_mem_stall();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (w_pat !== P_FREEZE) begin n_bad++; $display("FAIL mem_freeze[%0d] got %b want %b", i, w_pat, P_FREEZE); end
      @(negedge clk);
    end
    dmem_ready = 1'b1; #1;
    n_cmp++; if (w_pat !== P_RUN) begin n_bad++; $display("FAIL mem_ready got %b want %b", w_pat, P_RUN); end
    n_cmp++; if (stall_cycles !== 32'd3) begin n_bad++; $display("FAIL mem_stall_cnt got %0d want 3", stall_cycles); end
    @(negedge clk);
    dmem_req = 1'b0; dmem_ready = 1'b0; #1;
    n_cmp++; if (w_pat !== P_RUN) begin n_bad++; $display("FAIL mem_after got %b want %b", w_pat, P_RUN); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_priority();
    do_reset();
    IF_ID_inst = I_ADD_X6_X5_X1; set_ex(5'd5, 1'b1, 1'b1);
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (w_pat !== P_FREEZE) begin n_bad++; $display("FAIL prio_freeze[%0d] got %b want %b", i, w_pat, P_FREEZE); end
      @(negedge clk);
    end
    n_cmp++; if (load_use_stalls !== 32'd0) begin n_bad++; $display("FAIL prio_lu_frozen got %0d want 0", load_use_stalls); end
    dmem_ready = 1'b1; #1;
    n_cmp++; if (w_pat !== P_STALL) begin n_bad++; $display("FAIL prio_lu_after got %b want %b", w_pat, P_STALL); end
    @(negedge clk);
    idle_inputs(); #1;
    n_cmp++; if (w_pat !== P_RUN) begin n_bad++; $display("FAIL prio_resume got %b want %b", w_pat, P_RUN); end
    n_cmp++; if (load_use_stalls !== 32'd1) begin n_bad++; $display("FAIL prio_lu_cnt got %0d want 1", load_use_stalls); end
    n_cmp++; if (stall_cycles !== 32'd3) begin n_bad++; $display("FAIL prio_stall_cnt got %0d want 3", stall_cycles); end
    @(negedge clk);
  endtask

  task automatic test_reset_mem_wait();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1; #1;
    n_cmp++; if (w_pat !== P_RUN) begin n_bad++; $display("FAIL rst_wait_outputs got %b want %b", w_pat, P_RUN); end
    @(negedge clk);
    reset = 1'b0; dmem_req = 1'b0; #1;
    n_cmp++; if (w_pat !== P_RUN) begin n_bad++; $display("FAIL rst_wait_run got %b want %b", w_pat, P_RUN); end
    n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL rst_wait_cnt got %0d want 0", stall_cycles); end
    @(negedge clk);
    #1;
    n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL rst_wait_no_residual got %0d want 0", stall_cycles); end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_no_hazard();
    test_ecall();
    test_mem_stall();
    test_priority();
    test_reset_mem_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
